// File: rtl/feature_stream_tx.sv
// Byte-serial framer for the feature-extractor vector: sync byte, payload bytes, optional checksum.
// Define FEATURE_STREAM_XSUM_EN to append an XOR checksum byte after the payload.
module feature_stream_tx #(
    parameter int         NUM_FEATURES = 8,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] features,
    input  logic         feature_valid,
    output logic [7:0]   out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         frame_start,
    output logic         busy,
    output logic [7:0]   drop_cnt
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SYNC    = 2'd1;
    localparam logic [1:0] ST_PAYLOAD = 2'd2;
`ifdef FEATURE_STREAM_XSUM_EN
    localparam logic [1:0] ST_XSUM    = 2'd3;
`endif
    localparam logic [3:0] LAST_IDX   = 4'(NUM_FEATURES - 1);

    logic [1:0]   state_q, state_d;
    logic [3:0]   idx_q, idx_d;
    logic [127:0] snap_q, snap_d;
    logic [127:0] pend_q, pend_d;
    logic         pend_vld_q, pend_vld_d;
    logic [7:0]   drop_q, drop_d;
    logic [7:0]   out_data_q, out_data_d;
    logic         out_valid_q, out_valid_d;
    logic         frame_start_q, frame_start_d;
    logic         xfer;
    logic         eof;

`ifdef FEATURE_STREAM_XSUM_EN
    logic [7:0] xsum;

    // The snapshot is frozen for the whole frame, so folding it directly is safe.
    always_comb begin
        xsum = '0;
        for (int k = 0; k < NUM_FEATURES; k++) begin
            xsum = xsum ^ snap_q[8*k +: 8];
        end
    end
`endif

    assign xfer = out_valid_q & out_ready;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        snap_d     = snap_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        drop_d     = drop_q;
        eof        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (feature_valid) begin
                    snap_d  = features;
                    state_d = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (xfer) begin
                    state_d = ST_PAYLOAD;
                    idx_d   = '0;
                end
            end
            ST_PAYLOAD: begin
                if (xfer) begin
                    if (idx_q == LAST_IDX) begin
`ifdef FEATURE_STREAM_XSUM_EN
                        state_d = ST_XSUM;
`else
                        eof = 1'b1;
`endif
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
`ifdef FEATURE_STREAM_XSUM_EN
            ST_XSUM: begin
                if (xfer) eof = 1'b1;
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // A strobe landing on end-of-frame starts the next frame instead of counting as overflow.
        if (eof) begin
            if (pend_vld_q) begin
                snap_d  = pend_q;
                state_d = ST_SYNC;
                if (feature_valid) pend_d     = features;
                else               pend_vld_d = 1'b0;
            end else if (feature_valid) begin
                snap_d  = features;
                state_d = ST_SYNC;
            end else begin
                state_d = ST_IDLE;
            end
        end else if (state_q != ST_IDLE && feature_valid) begin
            pend_d     = features;
            pend_vld_d = 1'b1;
            if (pend_vld_q && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
        end
    end

    // Outputs are pre-computed from the next state so they can be registered.
    always_comb begin
        out_valid_d   = (state_d != ST_IDLE);
        frame_start_d = (state_d == ST_SYNC);
        case (state_d)
            ST_SYNC:    out_data_d = SYNC_BYTE;
            ST_PAYLOAD: out_data_d = snap_d[{idx_d, 3'b000} +: 8];
`ifdef FEATURE_STREAM_XSUM_EN
            ST_XSUM:    out_data_d = xsum;
`endif
            default:    out_data_d = 8'h00;
        endcase
    end

    // NOTE: state uses non-blocking assignments so all flops update together at the edge.
    // NOTE: the snapshot/pending data registers are reset too, so an aborted frame leaves no stale vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            snap_q        <= '0;
            pend_q        <= '0;
            pend_vld_q    <= 1'b0;
            drop_q        <= '0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            snap_q        <= snap_d;
            pend_q        <= pend_d;
            pend_vld_q    <= pend_vld_d;
            drop_q        <= drop_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign frame_start = frame_start_q;
    assign busy        = (state_q != ST_IDLE);
    assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_feature_stream_tx.sv
// Self-checking bench for feature_stream_tx: directed scenarios plus random traffic,
// compared every cycle against a frame-level reference model.
module tb_feature_stream_tx;

    localparam int         NF = 8;
    localparam logic [7:0] SB = 8'hA5;
`ifdef FEATURE_STREAM_XSUM_EN
    localparam int FL = NF + 2;
`else
    localparam int FL = NF + 1;
`endif

    logic         clk;
    logic         rst_n;
    logic [127:0] features;
    logic         feature_valid;
    logic [7:0]   out_data;
    logic         out_valid;
    logic         out_ready;
    logic         frame_start;
    logic         busy;
    logic [7:0]   drop_cnt;

    feature_stream_tx #(.NUM_FEATURES(NF), .SYNC_BYTE(SB)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .features(features),
        .feature_valid(feature_valid),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .frame_start(frame_start),
        .busy(busy),
        .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    // Reference model: the current frame as a byte list plus a read position.
    bit           m_busy;
    bit           m_pv;
    int           m_pos;
    int           m_drop;
    logic [127:0] m_pend;
    logic [7:0]   m_frame [FL];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_pv   = 1'b0;
        m_pos  = 0;
        m_drop = 0;
        m_pend = '0;
    endtask

    task automatic start_frame(input logic [127:0] v);
        logic [7:0] x;
        x = 8'h00;
        m_frame[0] = SB;
        for (int k = 0; k < NF; k++) begin
            m_frame[k+1] = v[8*k +: 8];
            x = x ^ v[8*k +: 8];
        end
`ifdef FEATURE_STREAM_XSUM_EN
        m_frame[NF+1] = x;
`endif
        m_pos  = 0;
        m_busy = 1'b1;
    endtask

    // Advance the model by one rising edge using the inputs that were presented to it.
    task automatic model_step();
        bit xfer;
        bit last;
        if (!rst_n) begin
            model_reset();
        end else if (!m_busy) begin
            if (feature_valid) start_frame(features);
        end else begin
            xfer = out_ready;
            last = xfer && (m_pos == FL - 1);
            if (xfer) m_pos++;
            if (last) begin
                if (m_pv) begin
                    start_frame(m_pend);
                    if (feature_valid) m_pend = features;
                    else               m_pv   = 1'b0;
                end else if (feature_valid) begin
                    start_frame(features);
                end else begin
                    m_busy = 1'b0;
                end
            end else if (feature_valid) begin
                if (m_pv && m_drop < 255) m_drop++;
                m_pend = features;
                m_pv   = 1'b1;
            end
        end
    endtask

    task automatic check_outputs();
        logic [7:0] ed;
        ed = m_busy ? m_frame[m_pos] : 8'h00;
        check("out_valid", out_valid, m_busy);
        check("out_data", out_data, ed);
        check("frame_start", frame_start, (m_busy && m_pos == 0));
        check("busy", busy, m_busy);
        check("drop_cnt", drop_cnt, m_drop);
    endtask

    task automatic sample();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic drive_edge(input logic fv, input logic [127:0] v, input logic rdy);
        feature_valid = fv;
        features      = v;
        out_ready     = rdy;
        @(posedge clk);
        model_step();
    endtask

    task automatic cycle(input logic fv, input logic [127:0] v, input logic rdy);
        sample();
        drive_edge(fv, v, rdy);
    endtask

    function automatic logic [127:0] rvec();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    logic [127:0] vdir;
    logic         bp_pat [4];
    int           o2, o3;

    initial begin
        vdir = {64'h0, 64'h0807060504030201};
        bp_pat[0] = 1'b1; bp_pat[1] = 1'b0; bp_pat[2] = 1'b0; bp_pat[3] = 1'b1;

        // Reset state
        rst_n = 1'b0; feature_valid = 1'b0; features = '0; out_ready = 1'b1;
        model_reset();
        #3;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_busy", busy, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        repeat (2) cycle(1'b0, '0, 1'b1);
        sample();
        rst_n = 1'b1;
        drive_edge(1'b0, '0, 1'b1);

        // Single frame, sink always ready
        cycle(1'b1, vdir, 1'b1);
        repeat (FL + 3) cycle(1'b0, '0, 1'b1);

        // Backpressure: ready toggles 1,0,0,1,...
        cycle(1'b1, vdir, 1'b1);
        for (int i = 0; i < 4 * FL + 4; i++) cycle(1'b0, '0, bp_pat[i % 4]);
        repeat (FL + 2) cycle(1'b0, '0, 1'b1);

        // Pending buffer: second vector three cycles into the first frame
        cycle(1'b1, rvec(), 1'b1);
        repeat (2) cycle(1'b0, '0, 1'b1);
        cycle(1'b1, rvec(), 1'b1);
        repeat (2 * FL + 2) cycle(1'b0, '0, 1'b1);
        check("pending_no_drop", drop_cnt, 0);

        // Coincident strobe on the cycle the last byte transfers
        cycle(1'b1, rvec(), 1'b1);
        repeat (FL - 1) cycle(1'b0, '0, 1'b1);
        cycle(1'b1, rvec(), 1'b1);
        sample();
        check("coinc_sync_byte", out_data, SB);
        check("coinc_frame_start", frame_start, 1);
        drive_edge(1'b0, '0, 1'b1);
        repeat (FL + 2) cycle(1'b0, '0, 1'b1);

        // Overflow: three strobes per frame, repeated until drop_cnt saturates
        for (int it = 0; it < 300; it++) begin
            o2 = $urandom_range(1, 3);
            o3 = $urandom_range(1, 3);
            cycle(1'b1, rvec(), 1'b1);
            repeat (o2 - 1) cycle(1'b0, '0, 1'b1);
            cycle(1'b1, rvec(), 1'b1);
            repeat (o3 - 1) cycle(1'b0, '0, 1'b1);
            cycle(1'b1, rvec(), 1'b1);
            repeat (2 * FL + 2) cycle(1'b0, '0, 1'b1);
            if (it == 0) check("overflow_one_drop", drop_cnt, 1);
        end
        check("drop_saturated", drop_cnt, 255);

        // Reset during payload byte 3
        cycle(1'b1, rvec(), 1'b1);
        repeat (4) cycle(1'b0, '0, 1'b1);
        sample();
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_data", out_data, 0);
        check("midrst_frame_start", frame_start, 0);
        check("midrst_busy", busy, 0);
        check("midrst_drop_cnt", drop_cnt, 0);
        drive_edge(1'b0, '0, 1'b1);
        repeat (2) cycle(1'b0, '0, 1'b1);
        sample();
        rst_n = 1'b1;
        drive_edge(1'b0, '0, 1'b1);
        cycle(1'b1, vdir, 1'b1);
        sample();
        check("postrst_sync", out_data, SB);
        drive_edge(1'b0, '0, 1'b1);
        repeat (FL + 2) cycle(1'b0, '0, 1'b1);

        // Random traffic and backpressure
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 9) == 0), rvec(), ($urandom_range(0, 3) != 0));
        end
        repeat (3 * FL) cycle(1'b0, '0, 1'b1);
        sample();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
